// File: rtl/rv_iret_arb_pkg.sv
// Shared constants and types for the in-order retirement arbiter.
package rv_iret_arb_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int FLEN_DEF    = 32;
  localparam int NREQ_DEF    = 3;
  localparam int TAGW_DEF    = 4;
  localparam int WDT_CYC_DEF = 1024;
  localparam int INSN_W      = 32;

  // Program-order sequence tag at the default width.
  typedef logic [TAGW_DEF-1:0] tag_t;

  // One retired-instruction record at the default widths.
  typedef struct packed {
    logic [XLEN_DEF-1:0] addr;
    logic [INSN_W-1:0]   insn;
    logic [XLEN_DEF-1:0] ires;
    logic [FLEN_DEF-1:0] fres;
  } retire_rec_t;

endpackage

// File: rtl/rv_iret_arb_sel.sv
// Tag compare and lowest-index priority select for the retirement arbiter.
// Purely combinational: one-hot grant vector plus a found flag.
module rv_iret_arb_sel
  import rv_iret_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*TAGW-1:0] req_tag,
  input  logic [TAGW-1:0]      exp_tag,
  output logic [NREQ-1:0]      grant,
  output logic                 found
);

  logic [NREQ-1:0] match;

  // A requester matches when it is valid and carries the expected tag.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_match
      assign match[gi] = req_valid[gi] && (req_tag[gi*TAGW +: TAGW] == exp_tag);
    end
  endgenerate

  // Lowest matching index wins; any further matches stay ungranted.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (match[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv_iret_arb.sv
// In-order retirement arbiter: grants the record whose tag equals the next
// expected tag and drives one registered retire record per cycle.
// Optional watchdog compiled in with `define RV_IRET_ARB_WDT_EN.
module rv_iret_arb
  import rv_iret_arb_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int FLEN    = FLEN_DEF,
  parameter int NREQ    = NREQ_DEF,
  parameter int TAGW    = TAGW_DEF,
  parameter int WDT_CYC = WDT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*TAGW-1:0] req_tag,
  input  logic [NREQ*XLEN-1:0] req_addr,
  input  logic [NREQ*32-1:0]   req_insn,
  input  logic [NREQ*XLEN-1:0] req_ires,
  input  logic [NREQ*FLEN-1:0] req_fres,
  input  logic                 flush,
  input  logic [TAGW-1:0]      flush_tag,
  output logic                 iret,
  output logic [XLEN-1:0]      addr,
  output logic [31:0]          insn,
  output logic [XLEN-1:0]      ires,
  output logic [FLEN-1:0]      fres,
  output logic                 wdt_err
);

  logic [TAGW-1:0] exp_tag_reg;
  logic [NREQ-1:0] grant;
  logic            found;
  logic [XLEN-1:0] sel_addr;
  logic [31:0]     sel_insn;
  logic [XLEN-1:0] sel_ires;
  logic [FLEN-1:0] sel_fres;

  rv_iret_arb_sel #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) u_sel (
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .exp_tag   (exp_tag_reg),
    .grant     (grant),
    .found     (found)
  );

  // Flush and reset suppress every ready bit, whatever matches.
  assign req_ready = (rst || flush) ? '0 : grant;

  // Grant is one-hot, so an AND-OR mux picks the granted record.
  always_comb begin
    sel_addr = '0;
    sel_insn = '0;
    sel_ires = '0;
    sel_fres = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr = sel_addr | ({XLEN{grant[i]}} & req_addr[i*XLEN +: XLEN]);
      sel_insn = sel_insn | ({32{grant[i]}}   & req_insn[i*32 +: 32]);
      sel_ires = sel_ires | ({XLEN{grant[i]}} & req_ires[i*XLEN +: XLEN]);
      sel_fres = sel_fres | ({FLEN{grant[i]}} & req_fres[i*FLEN +: FLEN]);
    end
  end

  // Expected-tag tracking and the registered retire port.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_tag_reg <= '0;
      iret        <= 1'b0;
      addr        <= '0;
      insn        <= '0;
      ires        <= '0;
      fres        <= '0;
    end else if (flush) begin
      exp_tag_reg <= flush_tag;
      iret        <= 1'b0;
    end else if (found) begin
      exp_tag_reg <= exp_tag_reg + 1'b1;
      iret        <= 1'b1;
      addr        <= sel_addr;
      insn        <= sel_insn;
      ires        <= sel_ires;
      fres        <= sel_fres;
    end else begin
      iret        <= 1'b0;
    end
  end

`ifdef RV_IRET_ARB_WDT_EN
  localparam int CNT_W = $clog2(WDT_CYC + 1);

  logic [CNT_W-1:0] wdt_cnt_reg;
  logic             wdt_err_reg;
  logic             stall;

  // A stall is a cycle with someone waiting but nobody granted and no flush.
  assign stall = (|req_valid) && !found && !flush;

  // Count consecutive stalls; raise a sticky error on reaching WDT_CYC.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt_reg <= '0;
      wdt_err_reg <= 1'b0;
    end else if (stall) begin
      if (wdt_cnt_reg != CNT_W'(WDT_CYC)) begin
        wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
      end
      if (wdt_cnt_reg >= CNT_W'(WDT_CYC - 1)) begin
        wdt_err_reg <= 1'b1;
      end
    end else begin
      wdt_cnt_reg <= '0;
    end
  end

  assign wdt_err = wdt_err_reg;
`else
  // No watchdog: the error output is constant 0 in this build.
  assign wdt_err = 1'b0 & (WDT_CYC == 0);
`endif

endmodule

// File: tb/tb_rv_iret_arb.sv
// Directed self-checking bench for rv_iret_arb.
module tb_rv_iret_arb;

  localparam int XLEN = 32;
  localparam int FLEN = 32;
  localparam int NREQ = 3;
  localparam int TAGW = 4;
  localparam int WDT_CYC = 8;
`ifdef RV_IRET_ARB_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [NREQ*XLEN-1:0] req_addr;
  logic [NREQ*32-1:0]   req_insn;
  logic [NREQ*XLEN-1:0] req_ires;
  logic [NREQ*FLEN-1:0] req_fres;
  logic                 flush;
  logic [TAGW-1:0]      flush_tag;
  logic                 iret;
  logic [XLEN-1:0]      addr;
  logic [31:0]          insn;
  logic [XLEN-1:0]      ires;
  logic [FLEN-1:0]      fres;
  logic                 wdt_err;

  int n_cmp = 0;
  int n_bad = 0;

  rv_iret_arb #(
    .XLEN (XLEN), .FLEN (FLEN), .NREQ (NREQ), .TAGW (TAGW), .WDT_CYC (WDT_CYC)
  ) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready), .req_tag (req_tag),
    .req_addr (req_addr), .req_insn (req_insn), .req_ires (req_ires),
    .req_fres (req_fres), .flush (flush), .flush_tag (flush_tag),
    .iret (iret), .addr (addr), .insn (insn), .ires (ires), .fres (fres),
    .wdt_err (wdt_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a record on requester i; insn/ires/fres derive from the PC.
  task automatic set_req(input int i, input logic v, input logic [TAGW-1:0] t,
                         input logic [XLEN-1:0] a);
    req_valid[i]             = v;
    req_tag[i*TAGW +: TAGW]  = t;
    req_addr[i*XLEN +: XLEN] = a;
    req_insn[i*32 +: 32]     = a ^ 32'hA5A5_0000;
    req_ires[i*XLEN +: XLEN] = a + 32'd1;
    req_fres[i*FLEN +: FLEN] = a + 32'd2;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
  endtask

  task automatic do_flush(input logic [TAGW-1:0] t);
    flush = 1'b1;
    flush_tag = t;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b1, 4'd0, 32'h0000_0050);
    tick();
    #1;
    n_cmp++;
    if (req_ready !== 3'b000) begin
      n_bad++; $display("FAIL reset_ready got %b want %b", req_ready, 3'b000);
    end
    tick();
    n_cmp++;
    if ({iret, addr, insn, ires, fres, wdt_err} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got iret=%b addr=%h insn=%h ires=%h fres=%h wdt=%b want all 0",
                        iret, addr, insn, ires, fres, wdt_err);
    end
    clear_reqs();
    rst = 1'b0;
    #1;
    $display("reset: outputs cleared");
  endtask

  task automatic test_sequential();
    set_req(0, 1'b1, 4'd0, 32'h0000_0100);
    set_req(1, 1'b1, 4'd1, 32'h0000_0104);
    #1;
    n_cmp++;
    if (req_ready !== 3'b001) begin
      n_bad++; $display("FAIL seq_ready0 got %b want %b", req_ready, 3'b001);
    end
    tick();
    n_cmp++;
    if (iret !== 1'b1 || addr !== 32'h100 || insn !== 32'hA5A5_0100) begin
      n_bad++; $display("FAIL seq_ret0 got iret=%b addr=%h insn=%h want 1 00000100 a5a50100", iret, addr, insn);
    end
    req_valid[0] = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 3'b010) begin
      n_bad++; $display("FAIL seq_ready1 got %b want %b", req_ready, 3'b010);
    end
    tick();
    n_cmp++;
    if (iret !== 1'b1 || addr !== 32'h104 || ires !== 32'h105 || fres !== 32'h106) begin
      n_bad++; $display("FAIL seq_ret1 got iret=%b addr=%h ires=%h fres=%h want 1 104 105 106", iret, addr, ires, fres);
    end
    clear_reqs();
    tick();
    n_cmp++;
    if (iret !== 1'b0 || addr !== 32'h104) begin
      n_bad++; $display("FAIL seq_hold got iret=%b addr=%h want 0 00000104", iret, addr);
    end
    $display("sequential: tags 0,1 retired");
  endtask

  task automatic test_out_of_order();
    do_flush(4'd0);
    set_req(2, 1'b1, 4'd1, 32'h0000_0204);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (req_ready !== 3'b000) begin
        n_bad++; $display("FAIL ooo_wait_ready c=%0d got %b want %b", c, req_ready, 3'b000);
      end
      tick();
      n_cmp++;
      if (iret !== 1'b0) begin
        n_bad++; $display("FAIL ooo_wait_iret c=%0d got %b want 0", c, iret);
      end
    end
    set_req(0, 1'b1, 4'd0, 32'h0000_0200);
    #1;
    n_cmp++;
    if (req_ready !== 3'b001) begin
      n_bad++; $display("FAIL ooo_ready0 got %b want %b", req_ready, 3'b001);
    end
    tick();
    req_valid[0] = 1'b0;
    #1;
    n_cmp++;
    if (iret !== 1'b1 || addr !== 32'h200 || req_ready !== 3'b100) begin
      n_bad++; $display("FAIL ooo_ret0 got iret=%b addr=%h ready=%b want 1 200 100", iret, addr, req_ready);
    end
    tick();
    clear_reqs();
    n_cmp++;
    if (iret !== 1'b1 || addr !== 32'h204) begin
      n_bad++; $display("FAIL ooo_ret1 got iret=%b addr=%h want 1 00000204", iret, addr);
    end
    $display("out_of_order: tag 1 waited, 0 then 1 retired");
  endtask

  task automatic test_wrap();
    logic [XLEN-1:0] exp_addr [4];
    exp_addr[0] = 32'h0000_0E00; exp_addr[1] = 32'h0000_0F00;
    exp_addr[2] = 32'h0000_1000; exp_addr[3] = 32'h0000_1100;
    do_flush(4'd14);
    set_req(0, 1'b1, 4'd14, exp_addr[0]);
    tick();
    n_cmp++;
    if (iret !== 1'b1 || addr !== exp_addr[0]) begin
      n_bad++; $display("FAIL wrap_ret0 got iret=%b addr=%h want 1 %h", iret, addr, exp_addr[0]);
    end
    clear_reqs();
    set_req(1, 1'b1, 4'd15, exp_addr[1]);
    tick();
    n_cmp++;
    if (iret !== 1'b1 || addr !== exp_addr[1]) begin
      n_bad++; $display("FAIL wrap_ret1 got iret=%b addr=%h want 1 %h", iret, addr, exp_addr[1]);
    end
    clear_reqs();
    set_req(2, 1'b1, 4'd0, exp_addr[2]);
    #1;
    n_cmp++;
    if (req_ready !== 3'b100) begin
      n_bad++; $display("FAIL wrap_ready_tag0 got %b want %b", req_ready, 3'b100);
    end
    tick();
    n_cmp++;
    if (iret !== 1'b1 || addr !== exp_addr[2]) begin
      n_bad++; $display("FAIL wrap_ret2 got iret=%b addr=%h want 1 %h", iret, addr, exp_addr[2]);
    end
    clear_reqs();
    set_req(0, 1'b1, 4'd1, exp_addr[3]);
    tick();
    n_cmp++;
    if (iret !== 1'b1 || addr !== exp_addr[3]) begin
      n_bad++; $display("FAIL wrap_ret3 got iret=%b addr=%h want 1 %h", iret, addr, exp_addr[3]);
    end
    // Expected tag must now be 2: only the tag-2 requester is ready.
    set_req(0, 1'b1, 4'd3, 32'h0000_1300);
    set_req(1, 1'b1, 4'd2, 32'h0000_1200);
    #1;
    n_cmp++;
    if (req_ready !== 3'b010) begin
      n_bad++; $display("FAIL wrap_exp2 got %b want %b", req_ready, 3'b010);
    end
    tick();
    clear_reqs();
    // Two requesters with the same tag 3: the lower index is granted.
    set_req(0, 1'b1, 4'd3, 32'h0000_1300);
    set_req(2, 1'b1, 4'd3, 32'h0000_2300);
    #1;
    n_cmp++;
    if (req_ready !== 3'b001) begin
      n_bad++; $display("FAIL multi_match_ready got %b want %b", req_ready, 3'b001);
    end
    tick();
    clear_reqs();
    n_cmp++;
    if (iret !== 1'b1 || addr !== 32'h1300) begin
      n_bad++; $display("FAIL multi_match_ret got iret=%b addr=%h want 1 00001300", iret, addr);
    end
    $display("wrap: tags 14,15,0,1 retired, then 2 and duplicate 3");
  endtask

  task automatic test_flush();
    do_flush(4'd5);
    set_req(0, 1'b1, 4'd5, 32'h0000_0500);
    flush = 1'b1;
    flush_tag = 4'd9;
    #1;
    n_cmp++;
    if (req_ready !== 3'b000) begin
      n_bad++; $display("FAIL flush_ready got %b want %b", req_ready, 3'b000);
    end
    tick();
    flush = 1'b0;
    n_cmp++;
    if (iret !== 1'b0 || addr !== 32'h1300) begin
      n_bad++; $display("FAIL flush_iret got iret=%b addr=%h want 0 00001300", iret, addr);
    end
    set_req(1, 1'b1, 4'd9, 32'h0000_0900);
    #1;
    n_cmp++;
    if (req_ready !== 3'b010) begin
      n_bad++; $display("FAIL flush_next_ready got %b want %b", req_ready, 3'b010);
    end
    tick();
    clear_reqs();
    n_cmp++;
    if (iret !== 1'b1 || addr !== 32'h900) begin
      n_bad++; $display("FAIL flush_next_ret got iret=%b addr=%h want 1 00000900", iret, addr);
    end
    $display("flush: tag 5 blocked, tag 9 granted next cycle");
  endtask

  task automatic test_watchdog();
    do_flush(4'd0);
    set_req(0, 1'b1, 4'd3, 32'h0000_0300);
    for (int c = 1; c <= 7; c++) tick();
    n_cmp++;
    if (wdt_err !== 1'b0) begin
      n_bad++; $display("FAIL wdt_early got %b want 0", wdt_err);
    end
    tick();
    n_cmp++;
    if (wdt_err !== WDT_ON) begin
      n_bad++; $display("FAIL wdt_rise got %b want %b", wdt_err, WDT_ON);
    end
    clear_reqs();
    tick();
    tick();
    n_cmp++;
    if (wdt_err !== WDT_ON) begin
      n_bad++; $display("FAIL wdt_sticky got %b want %b", wdt_err, WDT_ON);
    end
    $display("watchdog: wdt_err=%b after 8 stalls", wdt_err);
  endtask

  task automatic test_reset_mid();
    do_flush(4'd0);
    set_req(1, 1'b1, 4'd0, 32'h0000_0A00);
    tick();
    clear_reqs();
    n_cmp++;
    if (iret !== 1'b1 || addr !== 32'hA00) begin
      n_bad++; $display("FAIL rstmid_pre got iret=%b addr=%h want 1 00000a00", iret, addr);
    end
    rst = 1'b1;
    set_req(2, 1'b1, 4'd1, 32'h0000_0B00);
    #1;
    n_cmp++;
    if (req_ready !== 3'b000) begin
      n_bad++; $display("FAIL rstmid_ready got %b want %b", req_ready, 3'b000);
    end
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({iret, addr, insn, ires, fres, wdt_err} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs got iret=%b addr=%h insn=%h ires=%h fres=%h wdt=%b want all 0",
                        iret, addr, insn, ires, fres, wdt_err);
    end
    set_req(0, 1'b1, 4'd0, 32'h0000_0C00);
    #1;
    n_cmp++;
    if (req_ready !== 3'b001) begin
      n_bad++; $display("FAIL rstmid_ready_tag0 got %b want %b", req_ready, 3'b001);
    end
    tick();
    clear_reqs();
    n_cmp++;
    if (iret !== 1'b1 || addr !== 32'hC00) begin
      n_bad++; $display("FAIL rstmid_ret got iret=%b addr=%h want 1 00000c00", iret, addr);
    end
    $display("reset_mid: cleared, tag 0 granted afterwards");
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    flush_tag = '0;
    req_valid = '0;
    req_tag = '0;
    req_addr = '0;
    req_insn = '0;
    req_ires = '0;
    req_fres = '0;
    #2;
    test_reset();
    test_sequential();
    test_out_of_order();
    test_wrap();
    test_flush();
    test_watchdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_iret_arb.md
# rv_iret_arb

In-order retirement arbiter for the RV core's instruction-retire trace port. Several execution units (ALU, LSU, FPU, …) each present completed-instruction records tagged with a program-order sequence tag. The arbiter grants, each cycle, only the record whose tag equals the next expected tag. It drives one registered retire record per cycle onto the addr/insn/ires/fres/iret port consumed by the retirement monitor and trace logic.

## Interface
Parameters:
- XLEN, 32, integer register/address width
- FLEN, 32, FP result width
- NREQ, 3, number of requesting units (≥1)
- TAGW, 4, sequence tag width; tags wrap modulo 2^TAGW
- WDT_CYC, 1024, watchdog threshold in cycles (used only with the watchdog compiled in)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous and active-high
- req_valid  in  NREQ  record valid per requester
- req_ready  out  NREQ  record accepted this cycle (combinational)
- req_tag  in  NREQ×TAGW  program-order tag per requester
- req_addr  in  NREQ×XLEN  instruction PC
- req_insn  in  NREQ×32  instruction word
- req_ires  in  NREQ×XLEN  integer result
- req_fres  in  NREQ×FLEN  FP result
- flush  in  1  pipeline flush; reload expected tag
- flush_tag  in  TAGW  expected tag after flush
- iret  out  1  retire strobe, one record per high cycle
- addr / insn / ires / fres  out  XLEN / 32 / XLEN / FLEN  retired record
- wdt_err  out  1  sticky watchdog error

## Operation
- Internal exp_tag register, TAGW bits; reset value 0.
- Match: requester i matches when req_valid[i] && req_tag[i]==exp_tag.
- Grant: lowest-index matching requester; req_ready[i]=1 for the granted index only; all other ready bits are 0.
- Multiple matches are a protocol violation. The lowest index wins; the others stay unready.
- Grant cycle: iret<=1; addr/insn/ires/fres<=granted record; exp_tag<=exp_tag+1 (wraps 2^TAGW−1→0).
- No-grant cycle: iret<=0; addr/insn/ires/fres hold their last values; exp_tag holds.
- Output port has no backpressure. The arbiter never stalls on the output.
- flush=1: req_ready all 0; iret<=0; exp_tag<=flush_tag. Flush has priority over any match in that cycle.
- Non-matching valid requesters wait. They must hold valid and data stable until ready.
- rst=1, including mid-stream: exp_tag=0, iret=0, addr=insn=ires=fres=0, wdt_err=0, watchdog counter=0, req_ready all 0.

## Timing
- req_ready is combinational from req_valid, req_tag, exp_tag, flush and rst in the same cycle.
- Latency is 1 cycle: a record accepted at edge N appears on the outputs with iret=1 after edge N.
- Throughput is 1 record per cycle. Back-to-back tags from the same or different requesters retire on consecutive cycles.
- Flush takes effect at the next edge. A requester presenting flush_tag in the following cycle is granted in that cycle.

## Configuration
- Macro RV_IRET_ARB_WDT_EN.
- Defined:
  - TAGW-independent counter of $clog2(WDT_CYC+1) bits.
  - Increments each cycle when any req_valid=1, no grant occurs, and flush=0.
  - Cleared on grant, on flush, or when no requester is valid.
  - When the counter reaches WDT_CYC, wdt_err<=1. wdt_err is sticky until rst.
- Undefined: no counter is built; wdt_err is tied to 0. The port exists in both builds.

## Structure
- Package rv_iret_arb_pkg holds:
  - default width constants
  - the tag typedef
  - the retire record struct typedef (addr, insn, ires, fres), sized from package constants
- Sub-module rv_iret_arb_sel: purely combinational tag-compare and lowest-index priority select. Outputs a one-hot grant vector and a found flag.
- Top level holds exp_tag, the output register and the watchdog.

## Test plan
- Reset then sequential tags: req0 tag 0 addr 0x100, req1 tag 1 addr 0x104 both valid → ready0 at cycle 0; iret with addr 0x100 at cycle 1 and addr 0x104 at cycle 2.
- Out-of-order arrival: req2 tag 1 valid alone for 3 cycles, then req0 tag 0 → no iret for 3 cycles; then 0 and 1 retire back-to-back.
- Wrap: TAGW=4, retire tags 14, 15, 0, 1 on consecutive cycles → four consecutive iret pulses; exp_tag returns to 2.
- Flush mid-stream: exp_tag=5, flush with flush_tag=9 while req0 tag 5 is valid → req0 not granted, iret=0; next cycle req1 tag 9 is granted.
- Watchdog (WDT_EN, WDT_CYC=8): req0 valid with tag 3 while exp_tag=0 → wdt_err rises after the 8th stalled cycle and stays 1 until rst.
- Reset mid-operation: assert rst while iret=1 → next cycle all outputs 0, exp_tag 0; a requester with tag 0 is granted after rst deasserts.
